// File: rtl/link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : link_pkg
// Description : Shared widths and state encoding for the inter-board link.
// Revision    : 1.0
// ============================================================================
package link_pkg;

    localparam int MESSAGE_SIZE = 12;
    localparam int LINK_W       = 6;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        SETUP = 3'd2,
        PULSE = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } link_tx_state_t;

    function automatic int link_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/link_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : link_phase_timer
// Description : Loadable down-counter; expire is high on the last phase cycle.
// Revision    : 1.0
// ============================================================================
module link_phase_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_expire
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_run;

    // A load on the expiring cycle restarts the count without a dead cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_load) begin
            r_cnt <= i_load_val - CNT_W'(1);
            r_run <= 1'b1;
        end else if (r_run) begin
            if (r_cnt == '0) begin
                r_run <= 1'b0;
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign o_expire = r_run && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/link_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : link_tx_scheduler
// Description : Serialises datagrams onto the req/ack chunk link, latest-wins.
// Revision    : 1.0
// ============================================================================
module link_tx_scheduler #(
    parameter int MSG_W  = link_pkg::MESSAGE_SIZE,
    parameter int LINK_W = link_pkg::LINK_W,
    parameter int LEAD   = 4,
    parameter int SETUP  = 4,
    parameter int PULSE  = 8,
    parameter int HOLD   = 4,
    parameter int GAP    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MSG_W-1:0]  din,
    input  logic              din_valid,
    output logic [LINK_W-1:0] data_trans,
    output logic              req,
    output logic              ack,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        drop_cnt
);
    import link_pkg::*;

    localparam int c_NCHUNK = (MSG_W + LINK_W - 1) / LINK_W;
    localparam int c_SHW    = c_NCHUNK * LINK_W;
    localparam int c_CHW    = $clog2(c_NCHUNK) + 1;
    localparam int c_MAXP   = link_max(link_max(link_max(LEAD, SETUP),
                                                link_max(PULSE, HOLD)), GAP);
    localparam int c_CNT_W  = $clog2(c_MAXP) + 1;

    link_tx_state_t    r_state;
    logic [c_SHW-1:0]  r_shift;
    logic [MSG_W-1:0]  r_shadow;
    logic              r_pend;
    logic [7:0]        r_drop;
    logic [c_CHW-1:0]  r_chunk;
    logic [LINK_W-1:0] r_data;
    logic              r_req;
    logic              r_ack;
    logic              r_busy;

    logic               w_expire;
    logic               w_load;
    logic [c_CNT_W-1:0] w_load_val;
    logic               w_last;
    logic               w_gap_end;
    logic               w_start_next;
    logic [c_SHW-1:0]   w_src_pad;
    logic [c_SHW-1:0]   w_shifted;

    assign w_last       = (r_chunk == c_CHW'(c_NCHUNK - 1));
    assign w_gap_end    = (r_state == link_pkg::GAP) && w_expire;
    assign w_start_next = din_valid || r_pend;
    // A fresh din always beats the shadow copy; zero-extension pads the MSB end.
    assign w_src_pad    = c_SHW'(din_valid ? din : r_shadow);
    assign w_shifted    = r_shift << LINK_W;

    always_comb begin
        w_load     = 1'b0;
        w_load_val = c_CNT_W'(LEAD);
        case (r_state)
            link_pkg::IDLE: begin
                w_load     = din_valid;
                w_load_val = c_CNT_W'(LEAD);
            end
            link_pkg::LEAD: begin
                w_load     = w_expire;
                w_load_val = c_CNT_W'(SETUP);
            end
            link_pkg::SETUP: begin
                w_load     = w_expire;
                w_load_val = c_CNT_W'(PULSE);
            end
            link_pkg::PULSE: begin
                w_load     = w_expire;
                w_load_val = c_CNT_W'(HOLD);
            end
            link_pkg::HOLD: begin
                w_load     = w_expire;
                w_load_val = w_last ? c_CNT_W'(GAP) : c_CNT_W'(SETUP);
            end
            link_pkg::GAP: begin
                w_load     = w_expire && w_start_next;
                w_load_val = c_CNT_W'(LEAD);
            end
            default: begin
                w_load     = 1'b0;
                w_load_val = c_CNT_W'(LEAD);
            end
        endcase
    end

    link_phase_timer #(
        .CNT_W (c_CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expire   (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= link_pkg::IDLE;
            r_shift  <= '0;
            r_shadow <= '0;
            r_pend   <= 1'b0;
            r_drop   <= '0;
            r_chunk  <= '0;
            r_data   <= '0;
            r_req    <= 1'b0;
            r_ack    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            // Overwriting a still-pending datagram, either into the shadow or
            // by a direct load on the last gap cycle, counts as a drop.
            if (din_valid && r_pend && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
            if (din_valid && (r_state != link_pkg::IDLE) && !w_gap_end) begin
                r_shadow <= din;
                r_pend   <= 1'b1;
            end

            case (r_state)
                link_pkg::IDLE: begin
                    if (din_valid) begin
                        r_shift <= w_src_pad;
                        r_data  <= w_src_pad[c_SHW-1 -: LINK_W];
                        r_chunk <= '0;
                        r_req   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= link_pkg::LEAD;
                    end
                end
                link_pkg::LEAD: begin
                    if (w_expire) r_state <= link_pkg::SETUP;
                end
                link_pkg::SETUP: begin
                    if (w_expire) begin
                        r_ack   <= 1'b1;
                        r_state <= link_pkg::PULSE;
                    end
                end
                link_pkg::PULSE: begin
                    if (w_expire) begin
                        r_ack   <= 1'b0;
                        r_state <= link_pkg::HOLD;
                    end
                end
                link_pkg::HOLD: begin
                    if (w_expire) begin
                        if (w_last) begin
                            r_req   <= 1'b0;
                            r_data  <= '0;
                            r_state <= link_pkg::GAP;
                        end else begin
                            r_shift <= w_shifted;
                            r_data  <= w_shifted[c_SHW-1 -: LINK_W];
                            r_chunk <= r_chunk + c_CHW'(1);
                            r_state <= link_pkg::SETUP;
                        end
                    end
                end
                link_pkg::GAP: begin
                    if (w_expire) begin
                        if (w_start_next) begin
                            r_shift <= w_src_pad;
                            r_data  <= w_src_pad[c_SHW-1 -: LINK_W];
                            r_chunk <= '0;
                            r_req   <= 1'b1;
                            r_pend  <= 1'b0;
                            r_state <= link_pkg::LEAD;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= link_pkg::IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= link_pkg::IDLE;
                end
            endcase
        end
    end

    assign data_trans = r_data;
    assign req        = r_req;
    assign ack        = r_ack;
    assign busy       = r_busy;
    assign frame_done = w_gap_end;
    assign drop_cnt   = r_drop;

endmodule
`default_nettype wire
